frame_sequencer: RTL and testbench

- Per-frame controller in the clk_render domain.
- Sequences one frame as: framebuffer swap, render_manager begin_frame (clear), frame_driver start, wait for feed done, drain the pixel pipeline, then frame ready.
- Replaces the ad-hoc begin_frame/swap glue. Guarantees a swap only after a fully drawn frame; counts overrun (dropped) frame ticks.

---
 rtl/frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame swap / clear / draw / drain controller in the render clock domain.
// Define FRAME_SEQ_WATCHDOG_EN to add a watchdog that aborts a stuck DRAW/DRAIN and raises timeout_err.
module frame_sequencer #(
   parameter int DRAIN_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             scene_ready,
   input  logic             renderer_busy,
   input  logic             driver_done,
   output logic             swap,
   output logic             begin_frame,
   output logic             driver_start,
   output logic             frame_active,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             timeout_err
);

   localparam logic [2:0] WAIT_SCENE = 3'd0;
   localparam logic [2:0] READY      = 3'd1;
   localparam logic [2:0] SWAP       = 3'd2;
   localparam logic [2:0] START      = 3'd3;
   localparam logic [2:0] DRAW       = 3'd4;
   localparam logic [2:0] DRAIN      = 3'd5;

   localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   logic [1:0]    rst_sync;
   logic          rst_ok;
   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic          first_draw;
   logic [DW-1:0] drain_cnt;
   logic          drain_done;
   logic          tick_overrun;
   logic          wd_expired;

   // Reset asserts asynchronously but the sequencer only leaves reset two clocks after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_ok       = rst_sync[1];
   assign drain_done   = (state == DRAIN) && !renderer_busy && (drain_cnt == DRAIN_LAST);
   assign tick_overrun = frame_tick && ((state == SWAP) || (state == START) ||
                                        (state == DRAW) || (state == DRAIN));

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_SCENE: if (scene_ready && frame_tick) state_nxt = START;
         READY: begin
            if (!scene_ready)    state_nxt = WAIT_SCENE;
            else if (frame_tick) state_nxt = SWAP;
         end
         SWAP:  state_nxt = START;
         START: state_nxt = DRAW;
         DRAW: begin
            if (wd_expired)       state_nxt = READY;
            else if (driver_done) state_nxt = DRAIN;
         end
         DRAIN: if (wd_expired || drain_done) state_nxt = READY;
         default: state_nxt = WAIT_SCENE;
      endcase
   end

   // Drain counter only advances on consecutive idle cycles; any busy cycle restarts the wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_SCENE;
         first_draw  <= 1'b0;
         drain_cnt   <= '0;
         frame_count <= '0;
         drop_count  <= '0;
      end else if (!rst_ok) begin
         state       <= WAIT_SCENE;
         first_draw  <= 1'b0;
         drain_cnt   <= '0;
         frame_count <= '0;
         drop_count  <= '0;
      end else begin
         state      <= state_nxt;
         first_draw <= (state == START);
         if ((state != DRAIN) || renderer_busy) begin
            drain_cnt <= '0;
         end else begin
            drain_cnt <= drain_cnt + 1'b1;
         end
         if (drain_done && !wd_expired) begin
            frame_count <= frame_count + 1'b1;
         end
         if (tick_overrun && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

   assign swap         = (state == SWAP);
   assign begin_frame  = (state == START);
   assign driver_start = (state == DRAW) && first_draw;
   assign frame_active = (state == START) || (state == DRAW) || (state == DRAIN);

`ifdef FRAME_SEQ_WATCHDOG_EN
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] wd_cnt;
   logic        timeout_q;

   assign wd_expired = ((state == DRAW) || (state == DRAIN)) && (wd_cnt == WD_LAST);

   // An expired frame is abandoned to READY, so its partial image still gets swapped on the next tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else if (!rst_ok) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == START) begin
            wd_cnt <= '0;
         end else if ((state == DRAW) || (state == DRAIN)) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
         if (wd_expired) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`else
   assign wd_expired  = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed frames against a cycle-scheduled reference of the frame sequencer.
// Builds with or without FRAME_SEQ_WATCHDOG_EN; the watchdog build swaps the saturation run for a timeout run.
module tb_frame_sequencer;

   localparam int DRAIN = 8;
   localparam int CW    = 16;
`ifdef FRAME_SEQ_WATCHDOG_EN
   localparam int TIMEOUT = 100;
   localparam bit WD_EN   = 1'b1;
`else
   localparam int TIMEOUT = 2000000;
   localparam bit WD_EN   = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_tick;
   logic          scene_ready;
   logic          renderer_busy;
   logic          driver_done;
   logic          swap;
   logic          begin_frame;
   logic          driver_start;
   logic          frame_active;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] drop_count;
   logic          timeout_err;

   int tests_run    = 0;
   int tests_failed = 0;

   frame_sequencer #(
      .DRAIN_CYCLES   (DRAIN),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_tick    (frame_tick),
      .scene_ready   (scene_ready),
      .renderer_busy (renderer_busy),
      .driver_done   (driver_done),
      .swap          (swap),
      .begin_frame   (begin_frame),
      .driver_start  (driver_start),
      .frame_active  (frame_active),
      .frame_count   (frame_count),
      .drop_count    (drop_count),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual %0h, expected %0h at time %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change 1ns after a rising edge; single-cycle pulses are cleared after each edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         frame_tick  = 1'b0;
         driver_done = 1'b0;
      end
   endtask

   // Reference: a launched frame schedules its pulses at absolute cycle numbers, then counts idle cycles.
   int            cyc = 0;
   int            hold = 0;
   bit            m_busy, m_fed, m_swap_due, m_terr;
   int            t_swap, t_begin, t_dstart, idle_run, wd;
   logic [CW-1:0] m_frames, m_drops;

   task automatic modelReset();
      m_busy = 0; m_fed = 0; m_swap_due = 0; m_terr = 0;
      t_swap = -1; t_begin = -1; t_dstart = -1; idle_run = 0; wd = 0;
      m_frames = '0; m_drops = '0;
   endtask

   task automatic modelStep();
      if (m_busy) begin
         if (frame_tick && (m_drops != 16'hFFFF)) m_drops++;
         if (cyc >= t_dstart) begin
            wd++;
            if (WD_EN && (wd == TIMEOUT)) begin
               m_terr = 1; m_busy = 0; m_swap_due = 1;
            end else if (!m_fed) begin
               if (driver_done) begin
                  m_fed = 1; idle_run = 0;
               end
            end else begin
               idle_run = renderer_busy ? 0 : idle_run + 1;
               if (idle_run == DRAIN) begin
                  m_frames++; m_busy = 0; m_swap_due = 1;
               end
            end
         end
      end else if (m_swap_due && !scene_ready) begin
         m_swap_due = 0;
      end else if (frame_tick && scene_ready) begin
         t_swap     = m_swap_due ? cyc + 1 : -1;
         t_begin    = m_swap_due ? cyc + 2 : cyc + 1;
         t_dstart   = t_begin + 1;
         m_busy     = 1; m_fed = 0; wd = 0; m_swap_due = 0;
      end
   endtask

   initial modelReset();

   always @(negedge clk) begin
      if (!rst_n) begin
         modelReset();
         hold = 2;
      end
      checkOutput("mdl_swap",         swap,         (cyc == t_swap));
      checkOutput("mdl_begin_frame",  begin_frame,  m_busy && (cyc == t_begin));
      checkOutput("mdl_driver_start", driver_start, m_busy && (cyc == t_dstart));
      checkOutput("mdl_frame_active", frame_active, m_busy && (cyc >= t_begin));
      checkOutput("mdl_frame_count",  frame_count,  m_frames);
      checkOutput("mdl_drop_count",   drop_count,   m_drops);
      checkOutput("mdl_timeout_err",  timeout_err,  m_terr);
      if (rst_n) begin
         if (hold > 0) hold--;
         else modelStep();
      end
      cyc++;
   end

   logic [CW-1:0] exp_drop;

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; scene_ready = 1'b0; renderer_busy = 1'b0; driver_done = 1'b0;
      applyStimulus(3);
      checkOutput("rst_swap",   swap, 0);
      checkOutput("rst_begin",  begin_frame, 0);
      checkOutput("rst_active", frame_active, 0);
      checkOutput("rst_frames", frame_count, 0);
      checkOutput("rst_drops",  drop_count, 0);
      checkOutput("rst_tmo",    timeout_err, 0);
      rst_n = 1'b1;
      applyStimulus(3);

      // Ticks without a scene are ignored and never counted.
      repeat (3) begin
         frame_tick = 1'b1; applyStimulus(1);
         checkOutput("noscene_begin", begin_frame, 0);
         checkOutput("noscene_swap",  swap, 0);
      end
      checkOutput("noscene_drops", drop_count, 0);

      scene_ready = 1'b1; frame_tick = 1'b1; applyStimulus(1);
      checkOutput("f1_begin",  begin_frame, 1);
      checkOutput("f1_swap",   swap, 0);
      checkOutput("f1_active", frame_active, 1);
      applyStimulus(1);
      checkOutput("f1_dstart", driver_start, 1);
      applyStimulus(3);
      checkOutput("f1_dstart_once", driver_start, 0);
      driver_done = 1'b1; applyStimulus(1);
      applyStimulus(7);
      checkOutput("f1_drain8_frames", frame_count, 0);
      checkOutput("f1_drain8_active", frame_active, 1);
      applyStimulus(1);
      checkOutput("f1_done_frames", frame_count, 1);
      checkOutput("f1_done_active", frame_active, 0);

      // Tick from READY: swap +1, begin_frame +2, driver_start +3.
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("f2_swap", swap, 1);
      checkOutput("f2_swap_begin", begin_frame, 0);
      applyStimulus(1);
      checkOutput("f2_begin", begin_frame, 1);
      checkOutput("f2_begin_swap", swap, 0);
      applyStimulus(1);
      checkOutput("f2_dstart", driver_start, 1);
      driver_done = 1'b1; applyStimulus(1);
      applyStimulus(3);
      renderer_busy = 1'b1; applyStimulus(5);
      renderer_busy = 1'b0; applyStimulus(7);
      checkOutput("f2_busy_frames", frame_count, 1);
      checkOutput("f2_busy_active", frame_active, 1);
      applyStimulus(1);
      checkOutput("f2_done_frames", frame_count, 2);

      // Overrun ticks during DRAW are counted but not queued.
      frame_tick = 1'b1; applyStimulus(3);
      repeat (4) begin
         frame_tick = 1'b1; applyStimulus(1);
      end
      checkOutput("f3_drops", drop_count, 4);
      checkOutput("f3_active", frame_active, 1);
      driver_done = 1'b1; applyStimulus(9);
      checkOutput("f3_frames", frame_count, 3);
      checkOutput("f3_no_swap", swap, 0);

`ifdef FRAME_SEQ_WATCHDOG_EN
      frame_tick = 1'b1; applyStimulus(3);
      applyStimulus(99);
      checkOutput("wd_before", timeout_err, 0);
      checkOutput("wd_before_active", frame_active, 1);
      applyStimulus(1);
      checkOutput("wd_err", timeout_err, 1);
      checkOutput("wd_active", frame_active, 0);
      checkOutput("wd_frames", frame_count, 3);
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("wd_swap", swap, 1);
      applyStimulus(2);
      exp_drop = 16'd4;
`else
      frame_tick = 1'b1; applyStimulus(3);
      repeat (65530) begin
         frame_tick = 1'b1; applyStimulus(1);
      end
      checkOutput("sat_fffe", drop_count, 16'hFFFE);
      repeat (3) begin
         frame_tick = 1'b1; applyStimulus(1);
      end
      checkOutput("sat_ffff", drop_count, 16'hFFFF);
      checkOutput("sat_tmo", timeout_err, 0);
      exp_drop = 16'hFFFF;
`endif
      driver_done = 1'b1; applyStimulus(9);
      checkOutput("f4_frames", frame_count, 4);

      // Scene lost mid-frame: frame finishes, then no swap on the next tick.
      frame_tick = 1'b1; applyStimulus(3);
      scene_ready = 1'b0; driver_done = 1'b1; applyStimulus(9);
      checkOutput("scene_frames", frame_count, 5);
      checkOutput("scene_active", frame_active, 0);
      applyStimulus(2);
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("scene_no_swap",  swap, 0);
      checkOutput("scene_no_begin", begin_frame, 0);
      checkOutput("scene_drops",    drop_count, exp_drop);
      scene_ready = 1'b1; frame_tick = 1'b1; applyStimulus(1);
      checkOutput("rescene_begin", begin_frame, 1);
      checkOutput("rescene_swap",  swap, 0);
      driver_done = 1'b1; applyStimulus(1);
      checkOutput("rescene_dstart", driver_start, 1);
      applyStimulus(12);
      checkOutput("ignored_done_active", frame_active, 1);
      checkOutput("ignored_done_frames", frame_count, 5);
      driver_done = 1'b1; applyStimulus(9);
      checkOutput("rescene_frames", frame_count, 6);

      // driver_done on the first DRAW cycle, and a tick on the completing DRAIN cycle.
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("f7_swap", swap, 1);
      applyStimulus(2);
      driver_done = 1'b1; applyStimulus(1);
      applyStimulus(7);
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("f7_frames", frame_count, 7);
      checkOutput("f7_drops", drop_count, (exp_drop == 16'hFFFF) ? 16'hFFFF : exp_drop + 16'd1);
      checkOutput("f7_no_swap", swap, 0);

      // Async reset mid-DRAW clears everything at once.
      frame_tick = 1'b1; applyStimulus(3);
      checkOutput("mid_dstart", driver_start, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_dstart", driver_start, 0);
      checkOutput("arst_active", frame_active, 0);
      checkOutput("arst_frames", frame_count, 0);
      checkOutput("arst_drops",  drop_count, 0);
      checkOutput("arst_tmo",    timeout_err, 0);
      applyStimulus(2);
      rst_n = 1'b1;
      applyStimulus(3);
      frame_tick = 1'b1; applyStimulus(1);
      checkOutput("post_begin", begin_frame, 1);
      checkOutput("post_swap", swap, 0);
      applyStimulus(1);
      driver_done = 1'b1; applyStimulus(9);
      checkOutput("post_frames", frame_count, 1);
      applyStimulus(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
